// File: rtl/motor_ramp_sequencer_if.sv
// Command channel into the motor ramp sequencer: requested direction and duty
// transferred on a valid/ready handshake.
interface motor_ramp_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [6:0] cmd_duty;

  modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_sequencer.sv
// Soft-start/soft-stop PWM sequencer for one H-bridge channel: ramps duty in 1 % steps,
// and on reversal ramps to zero, flips direction and holds a dead time before re-enabling.
module motor_ramp_sequencer #(
  parameter int unsigned STEP_DIV     = 1250,
  parameter int unsigned RAMP_PERIODS = 10,
  parameter int unsigned DEAD_TIME    = 124999999
) (
  input  logic                         clk,
  input  logic                         rst,
  motor_ramp_sequencer_if.slave        cmd,
  input  logic                         stop,
  output logic                         motor_dir,
  output logic                         motor_en,
  output logic [6:0]                   cur_duty,
  output logic                         busy
);

  localparam int unsigned PsW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned RcW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PsW-1:0] PsLast   = PsW'(STEP_DIV - 1);
  localparam logic [RcW-1:0] RcLast   = RcW'(RAMP_PERIODS - 1);
  localparam logic [26:0]    DeadLast = 27'(DEAD_TIME - 1);

  typedef enum logic [1:0] {StIdle, StRun, StRampDown, StDead} state_e;

  state_e           state_q, state_d;
  logic             cur_dir_q, cur_dir_d;
  logic [6:0]       cur_duty_q, cur_duty_d;
  logic [6:0]       target_q, target_d;
  logic             pend_dir_q, pend_dir_d;
  logic [6:0]       pend_duty_q, pend_duty_d;
  logic [PsW-1:0]   prescale_q, prescale_d;
  logic [6:0]       step_q, step_d;
  logic [RcW-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [26:0]      dead_cnt_q, dead_cnt_d;
  logic             motor_en_q, motor_en_d;
  logic             motor_dir_q, motor_dir_d;

  logic             running, pb, rt, accept;
  logic [6:0]       cmd_duty_clamped, duty_stepped;

  assign running          = (state_q == StRun) || (state_q == StRampDown);
  assign pb               = running && (prescale_q == PsLast) && (step_q == 7'd99);
  assign rt               = pb && (ramp_cnt_q == RcLast);
  assign cmd.cmd_ready    = ((state_q == StIdle) || (state_q == StRun)) && !stop;
  assign accept           = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_duty_clamped = (cmd.cmd_duty > 7'd100) ? 7'd100 : cmd.cmd_duty;

  // Duty as it will be after this cycle's ramp tick (unchanged off-tick).
  always_comb begin
    duty_stepped = cur_duty_q;
    if (rt) begin
      if (cur_duty_q < target_q) begin
        duty_stepped = cur_duty_q + 7'd1;
      end else if (cur_duty_q > target_q) begin
        duty_stepped = cur_duty_q - 7'd1;
      end
    end
  end

  // PWM timebase; held at zero outside RUN/RAMP_DOWN so every RUN entry starts a fresh period.
  always_comb begin
    prescale_d = '0;
    step_d     = '0;
    ramp_cnt_d = '0;
    if (running && !stop) begin
      prescale_d = prescale_q + 1'b1;
      step_d     = step_q;
      ramp_cnt_d = ramp_cnt_q;
      if (prescale_q == PsLast) begin
        prescale_d = '0;
        step_d     = (step_q == 7'd99) ? 7'd0 : step_q + 7'd1;
        if (step_q == 7'd99) begin
          ramp_cnt_d = (ramp_cnt_q == RcLast) ? '0 : ramp_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_dir_d   = cur_dir_q;
    cur_duty_d  = cur_duty_q;
    target_d    = target_q;
    pend_dir_d  = pend_dir_q;
    pend_duty_d = pend_duty_q;
    dead_cnt_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d = cmd_duty_clamped;
          if (cmd.cmd_dir == cur_dir_q) begin
            state_d = StRun;
          end else begin
            cur_dir_d = cmd.cmd_dir;
            state_d   = StDead;
          end
        end
      end
      StRun: begin
        cur_duty_d = duty_stepped;
        if (accept) begin
          if (cmd.cmd_dir == cur_dir_q) begin
            target_d = cmd_duty_clamped;
          end else begin
            pend_dir_d  = cmd.cmd_dir;
            pend_duty_d = cmd_duty_clamped;
            target_d    = '0;
            state_d     = StRampDown;
          end
        end else if (pb && (duty_stepped == '0) && (target_q == '0)) begin
          state_d = StIdle;
        end
      end
      StRampDown: begin
        cur_duty_d = duty_stepped;
        // Leave on the boundary that ends the last non-zero period; EN is already low there.
        if (pb && (duty_stepped == '0)) begin
          state_d   = StDead;
          cur_dir_d = pend_dir_q;
          target_d  = pend_duty_q;
        end
      end
      StDead: begin
        if (dead_cnt_q == DeadLast) begin
          state_d = StRun;
        end else begin
          dead_cnt_d = dead_cnt_q + 27'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (stop) begin
      state_d     = StIdle;
      cur_duty_d  = '0;
      target_d    = '0;
      pend_dir_d  = 1'b0;
      pend_duty_d = '0;
      dead_cnt_d  = '0;
    end
  end

  assign motor_en_d  = running && (step_q < cur_duty_q) && !stop;
  assign motor_dir_d = cur_dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_dir_q   <= 1'b0;
      cur_duty_q  <= '0;
      target_q    <= '0;
      pend_dir_q  <= 1'b0;
      pend_duty_q <= '0;
      prescale_q  <= '0;
      step_q      <= '0;
      ramp_cnt_q  <= '0;
      dead_cnt_q  <= '0;
      motor_en_q  <= 1'b0;
      motor_dir_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      cur_duty_q  <= cur_duty_d;
      target_q    <= target_d;
      pend_dir_q  <= pend_dir_d;
      pend_duty_q <= pend_duty_d;
      prescale_q  <= prescale_d;
      step_q      <= step_d;
      ramp_cnt_q  <= ramp_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      motor_en_q  <= motor_en_d;
      motor_dir_q <= motor_dir_d;
    end
  end

  assign motor_en  = motor_en_q;
  assign motor_dir = motor_dir_q;
  assign cur_duty  = cur_duty_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with a short timebase: 200-cycle PWM periods,
// one duty step per period, 10-cycle dead time.
module tb_motor_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       motor_dir;
  logic       motor_en;
  logic [6:0] cur_duty;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  logic prev_dir = 1'b0;
  logic prev_en  = 1'b0;

  motor_ramp_sequencer_if cmd_if ();

  motor_ramp_sequencer #(
    .STEP_DIV     (2),
    .RAMP_PERIODS (1),
    .DEAD_TIME    (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .stop      (stop),
    .motor_dir (motor_dir),
    .motor_en  (motor_en),
    .cur_duty  (cur_duty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 ns later; any DIR change must happen with EN low on both sides.
  task automatic tick();
    @(posedge clk);
    #1;
    if (motor_dir != prev_dir) begin
      check_eq("dir_flip_en", motor_en, 0);
      check_eq("dir_flip_en_prev", prev_en, 0);
    end
    prev_dir = motor_dir;
    prev_en  = motor_en;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic dir, input logic [6:0] duty);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_duty  = duty;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int highs;
    rst              = 1'b1;
    stop             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_duty  = 7'd0;
    ticks(3);
    rst = 1'b0;
    tick();

    check_eq("rst_en", motor_en, 0);
    check_eq("rst_dir", motor_dir, 0);
    check_eq("rst_duty", cur_duty, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_if.cmd_ready, 1);

    // Soft start to 5 %
    send(1'b0, 7'd5);
    check_eq("start_busy", busy, 1);
    ticks(199);
    check_eq("start_duty_hold0", cur_duty, 0);
    tick();
    check_eq("start_duty1", cur_duty, 1);
    for (int d = 2; d <= 5; d++) begin
      ticks(200);
      check_eq("start_duty", cur_duty, d);
    end
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) check_eq("pwm5_first", motor_en, 1);
      if (i == 10) check_eq("pwm5_fall", motor_en, 0);
      highs += int'(motor_en);
    end
    check_eq("pwm5_high_cycles", highs, 10);

    // Clamped retarget upward, then mid-ramp retarget down to 3
    send(1'b0, 7'd120);
    ticks(199);
    check_eq("up_duty6", cur_duty, 6);
    ticks(200);
    check_eq("up_duty7", cur_duty, 7);
    check_eq("run_ready", cmd_if.cmd_ready, 1);
    send(1'b0, 7'd3);
    ticks(199);
    check_eq("down_duty6", cur_duty, 6);
    for (int d = 5; d >= 3; d--) begin
      ticks(200);
      check_eq("down_duty", cur_duty, d);
      check_eq("down_busy", busy, 1);
    end
    ticks(200);
    check_eq("down_hold3", cur_duty, 3);

    // Reversal to DIR=1, 4 %
    send(1'b1, 7'd4);
    check_eq("rev_ready_low", cmd_if.cmd_ready, 0);
    check_eq("rev_busy", busy, 1);
    ticks(199);
    check_eq("rev_duty2", cur_duty, 2);
    ticks(200);
    check_eq("rev_duty1", cur_duty, 1);
    ticks(200);
    check_eq("rev_duty0", cur_duty, 0);
    check_eq("rev_dead_ready", cmd_if.cmd_ready, 0);
    check_eq("rev_dir_before", motor_dir, 0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) check_eq("rev_dir_flipped", motor_dir, 1);
      if (i == 8) check_eq("dead_last_ready", cmd_if.cmd_ready, 0);
      if (i == 9) check_eq("dead_exit_ready", cmd_if.cmd_ready, 1);
      highs += int'(motor_en);
    end
    check_eq("dead_en_high_cycles", highs, 0);
    ticks(200);
    check_eq("rev_up_duty1", cur_duty, 1);
    ticks(200);
    check_eq("rev_up_duty2", cur_duty, 2);

    // STOP during ramp with a command pending
    stop             = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_duty  = 7'd50;
    #1;
    check_eq("stop_ready", cmd_if.cmd_ready, 0);
    tick();
    stop             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check_eq("stop_en", motor_en, 0);
    check_eq("stop_duty", cur_duty, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_dir_hold", motor_dir, 1);
    tick();
    check_eq("stop_not_accepted", busy, 0);

    // Full-scale clamp: 120 % from IDLE with opposite direction (via dead time)
    send(1'b0, 7'd120);
    check_eq("clamp_dead_busy", busy, 1);
    check_eq("clamp_dead_ready", cmd_if.cmd_ready, 0);
    ticks(10);
    check_eq("clamp_run_ready", cmd_if.cmd_ready, 1);
    for (int n = 1; n <= 100; n++) begin
      ticks(200);
      if (n == 50) check_eq("clamp_duty50", cur_duty, 50);
    end
    check_eq("clamp_duty100", cur_duty, 100);
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      highs += int'(motor_en);
    end
    check_eq("pwm100_high_cycles", highs, 200);
    check_eq("clamp_hold100", cur_duty, 100);

    // Asynchronous reset while in DEAD
    stop = 1'b1;
    tick();
    stop = 1'b0;
    send(1'b1, 7'd1);
    tick();
    check_eq("dead2_dir", motor_dir, 1);
    check_eq("dead2_busy", busy, 1);
    check_eq("dead2_ready", cmd_if.cmd_ready, 0);
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_dir", motor_dir, 0);
    check_eq("arst_en", motor_en, 0);
    check_eq("arst_duty", cur_duty, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", cmd_if.cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

Command-driven sequencer for one brushed DC motor H-bridge channel (DIR + EN pins). It accepts direction/duty commands over a valid/ready handshake and generates the PWM enable. Duty ramps in 1 % steps toward the target (soft start and soft stop). On a reversal it ramps to zero, flips direction and enforces a dead time before re-enabling. It replaces direct switch/button drive of the bridge and sits between the board-level command source and the motor pins.

## Interface
- STEP_DIV, 1250: CLK cycles per PWM step; 100 steps per PWM period (1 kHz at 125 MHz).
- RAMP_PERIODS, 10: PWM periods per 1 % duty change (1 s for 0→100 %).
- DEAD_TIME, 27'd124999999: CLK cycles EN is held low after a direction flip (1 s).
- CLK  in  1  system clock, 125 MHz.
- RST  in  1  reset; asynchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command can be accepted; transfer when CMD_VALID & CMD_READY on a rising edge.
- CMD_DIR  in  1  requested direction.
- CMD_DUTY  in  7  requested duty in percent; values >100 clamp to 100.
- STOP  in  1  emergency stop, level, synchronous sample.
- MOTOR_DIR  out  1  bridge direction, registered.
- MOTOR_EN  out  1  bridge enable (PWM), registered.
- CUR_DUTY  out  7  present applied duty, percent.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, RAMP_DOWN, DEAD.
- Registers: cur_dir, cur_duty, target, pend_dir, pend_duty, prescale (0..STEP_DIV-1), step (0..99), ramp_cnt (0..RAMP_PERIODS-1), dead_cnt (27 bit).
- Period boundary (PB): prescale==STEP_DIV-1 && step==99. Ramp tick (RT): PB && ramp_cnt==RAMP_PERIODS-1.
- prescale, step and ramp_cnt run only in RUN/RAMP_DOWN. They clear to 0 on every entry to RUN from IDLE or DEAD.
- CMD_READY = 1 in IDLE and RUN, 0 in RAMP_DOWN and DEAD, 0 while STOP=1.
- IDLE, command accepted: target←clamp(CMD_DUTY).
  - If CMD_DIR==cur_dir → RUN.
  - Else cur_dir←CMD_DIR and → DEAD.
- RUN, same-direction command: target←clamp(CMD_DUTY) and stay in RUN; the ramp continues from cur_duty.
- RUN, opposite-direction command: pend_dir/pend_duty←command, target←0, → RAMP_DOWN.
- RUN/RAMP_DOWN on RT: cur_duty moves 1 toward target (+1, −1 or hold).
- RUN → IDLE on PB when cur_duty==0 && target==0.
- RAMP_DOWN → DEAD on PB when cur_duty==0. On that transition cur_dir←pend_dir and target←pend_duty.
- DEAD: dead_cnt counts 0..DEAD_TIME-1, then → RUN with dead_cnt cleared.
- MOTOR_EN next = (state∈{RUN,RAMP_DOWN}) && step < cur_duty.
  - 0 % gives constant low; 100 % gives constant high.
  - EN is always 0 in IDLE and DEAD.
- MOTOR_DIR next = cur_dir. MOTOR_DIR never changes while MOTOR_EN=1.
- STOP=1 (any state): next cycle MOTOR_EN=0, cur_duty=0, target=0, pend cleared, → IDLE. MOTOR_DIR holds. STOP has priority over a simultaneous command, which is not accepted.
- Reset values: state IDLE, all counters 0, cur_dir 0, cur_duty 0, target 0.
  - Outputs: MOTOR_DIR=0, MOTOR_EN=0, CUR_DUTY=0, BUSY=0, CMD_READY=1.
- Reset mid-operation returns immediately (asynchronously) to these values.

## Timing
- Command accept edge → state change visible the following cycle.
- MOTOR_EN/MOTOR_DIR lag their internal conditions by 1 cycle (registered).
- PWM period = 100×STEP_DIV cycles. EN high for exactly cur_duty×STEP_DIV cycles per period, starting at step 0.
- cur_duty updates only at a period end, so there are no partial-period glitches.
- Reversal from duty D: D×RAMP_PERIODS periods of ramp-down, then exactly DEAD_TIME cycles with EN=0. DIR flips on the first DEAD cycle.
- Counter widths: prescale ≥ clog2(STEP_DIV), ramp_cnt ≥ clog2(RAMP_PERIODS). Duty compare is 7-bit unsigned.

## Test plan
Bench parameters: STEP_DIV=2, RAMP_PERIODS=1, DEAD_TIME=10.
- Reset: after RST drop → MOTOR_EN=0, MOTOR_DIR=0, CUR_DUTY=0, BUSY=0, CMD_READY=1.
- Soft start: command DIR=0, DUTY=5 → CUR_DUTY steps 0,1..5, one step per 200 cycles. In the 5 % period, EN is high 10 cycles then low 190.
- Clamp and retarget: command DUTY=120 → target 100, CUR_DUTY ramps up. Mid-ramp command DUTY=3 → CUR_DUTY ramps down to 3 without leaving RUN.
- Reversal: at duty 3, command DIR=1, DUTY=4 → CMD_READY drops and CUR_DUTY goes 3→0. Then DIR flips with EN held low for 10 cycles, then CUR_DUTY ramps 0→4. EN is never 1 while DIR changes.
- STOP: assert during ramp with CMD_VALID=1 → next cycle EN=0, CUR_DUTY=0, IDLE, command not accepted.
- Async reset during DEAD → outputs at reset values without waiting for a clock edge.
